safety_monitor_mc: RTL and testbench
====================================

Name: safety_monitor_mc

Overview:
Parametrised multi-channel successor to the SoC safety monitor. It collects NUM_ALARMS active-low alarm lines from safety mechanisms such as lockstep comparators, ECC and watchdogs. Each line passes a per-channel mask and a persistence filter. From the filtered lines the block drives a sticky active-low SoC error alarm, a sticky per-channel error code, first-fault capture, a saturating fault counter, and a software clear with a recovery hold-off.

Parameters:
NUM_ALARMS, 5, number of alarm channels (1..32)
FILTER_CYCLES, 2, consecutive asserted samples needed before a channel counts as faulted (1..15)
HOLDOFF_CYCLES, 4, cycles spent in RECOVER after an accepted clear (1..255)
CNT_W, 4, width of the fault event counter
IDX_W, $clog2(NUM_ALARMS) with a minimum of 1, width of the first-fault index

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
alarm_in_n  in  NUM_ALARMS  alarm lines, active-low, already synchronous to clk
alarm_mask  in  NUM_ALARMS  1 = channel ignored
clear_i  in  1  single-cycle clear request
sf_error_alarm_o  out  1  SoC error alarm, active-low, sticky
sf_error_code_o  out  NUM_ALARMS  sticky record of filtered faults per channel
sf_first_fault_o  out  IDX_W  index of the channel that caused the last entry to FAULT
sf_first_valid_o  out  1  sf_first_fault_o is valid
sf_fault_cnt_o  out  CNT_W  number of FAULT entries since reset, saturating
sf_state_o  out  2  FSM state: 0 OK, 1 FAULT, 2 RECOVER

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - sf_error_alarm_o=1, sf_error_code_o=0, sf_first_fault_o=0, sf_first_valid_o=0
  - sf_fault_cnt_o=0, state=OK, all filter counters=0, all filt=0
- Channel raw active: raw[i] = ~alarm_in_n[i] & ~alarm_mask[i].
- Filter, per channel, counter width 4 bits:
  - raw=1: counter increments, saturating at FILTER_CYCLES.
  - raw=0: counter and filt[i] go to 0 on the next edge.
  - filt[i] is registered and equals 1 when the counter equals FILTER_CYCLES.
  - A single-cycle glitch is rejected when FILTER_CYCLES>1.
  - With FILTER_CYCLES=1, filt follows raw one cycle late.
- any_filt = OR of filt.
- Latency: input asserted from cycle 0 gives filt=1 after edge FILTER_CYCLES, and sf_error_alarm_o=0 after edge FILTER_CYCLES+1.
- FSM (registered; all outputs are registers):
  - OK: sf_error_alarm_o=1. If any_filt, go to FAULT and on the same edge:
    - sf_error_alarm_o<=0
    - sf_first_fault_o<=lowest index with filt=1
    - sf_first_valid_o<=1
    - sf_fault_cnt_o increments, saturating at all-ones
  - FAULT: sf_error_alarm_o=0.
    - If clear_i & ~any_filt, go to RECOVER and load the hold-off counter with HOLDOFF_CYCLES-1.
    - If clear_i & any_filt, clear_i is ignored and the state stays FAULT; a new fault wins over the clear.
  - RECOVER: sf_error_alarm_o stays 0; the hold-off counter decrements.
    - If any_filt, go to FAULT and do the same capture and count increment as from OK.
    - Else, when the counter is 0, go to OK and set sf_error_alarm_o<=1.
    - clear_i is ignored in RECOVER.
- sf_error_code_o:
  - Every cycle: code <= code | filt.
  - On the FAULT->RECOVER edge: code <= filt, which is 0.
  - It therefore accumulates every channel that faulted since the last accepted clear.
- sf_first_valid_o goes to 0 on the FAULT->RECOVER edge. sf_first_fault_o holds its value.
- Masking:
  - Setting the mask bit clears raw immediately, so the counter and filt clear on the next edge.
  - Masking does not clear sticky code bits or leave FAULT.
  - Mask changes take effect on the next edge.
- Simultaneous faults on several channels: all are recorded in code; the first-fault index is the lowest of them.
- Reset mid-operation, in any state, returns every output to its reset value asynchronously.

Decomposition:
- Package safety_monitor_pkg holds:
  - state encoding localparams ST_OK=2'd0, ST_FAULT=2'd1, ST_RECOVER=2'd2
  - the filter counter width FILT_W=4
- One sub-module, safety_monitor_filter: the per-channel persistence counter producing filt.
  - Parameter FILTER_CYCLES.
  - Ports clk, rst_n, raw_i, filt_o.
  - Instantiated NUM_ALARMS times in a generate loop.
- The top holds the FSM, the priority encoder, the sticky code register and the counters.

Test Plan:
- Defaults; alarm_in_n=5'b11011 held → filt[2] after 2 edges; sf_error_alarm_o=0 at edge 3; code=5'b00100; first_fault=2, valid=1; cnt=1.
- 1-cycle glitch on channel 0 with FILTER_CYCLES=2 → no FAULT; alarm stays 1; code=0.
- Channels 1 and 3 asserted in the same cycle → first_fault=1; code=5'b01010.
- In FAULT with channel 3 still active, pulse clear_i → stays FAULT. Release channel 3, wait 1 edge, pulse clear → RECOVER. Alarm stays 0 for 4 cycles, then returns to 1; code=0; valid=0.
- In RECOVER, assert channel 4 for 2 cycles → FAULT; cnt=2; first_fault=4.
- Masked channel held low → no reaction; cnt saturates at 15 after 16 fault/clear cycles; rst_n=0 mid-FAULT → all outputs at reset values immediately.

Source files
------------

// File: rtl/safety_monitor_pkg.sv
// Shared definitions for the multi-channel safety monitor.
//   state_t : FSM state encoding, also driven out on sf_state_o
//   FILT_W  : width of the per-channel persistence counter
package safety_monitor_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam int FILT_W = 4;

endpackage

// File: rtl/safety_monitor_filter.sv
// Per-channel persistence filter. filt_o rises once raw_i has been seen
// high on FILTER_CYCLES consecutive edges, and drops on the first edge
// that sees raw_i low.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   raw_i  : unmasked, active-high channel request
//   filt_o : registered, filtered fault indication
module safety_monitor_filter
  import safety_monitor_pkg::*;
#(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [FILT_W-1:0] CNT_MAX = FILT_W'(FILTER_CYCLES);

  logic [FILT_W-1:0] cnt_reg;
  logic [FILT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (raw_i) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  // filt is derived from the counter value being loaded, so it rises on
  // the same edge the counter reaches FILTER_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      filt_o  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      filt_o  <= (cnt_next == CNT_MAX);
    end
  end

endmodule

// File: rtl/safety_monitor_mc.sv
// Multi-channel safety monitor. Masks and filters NUM_ALARMS active-low
// alarm lines, then drives a sticky SoC alarm with first-fault capture,
// a sticky per-channel error code, a saturating fault counter and a
// software clear followed by a recovery hold-off.
//   clk, rst_n       : clock, asynchronous active-low reset
//   alarm_in_n       : alarm lines, active-low, synchronous to clk
//   alarm_mask       : 1 = channel ignored
//   clear_i          : single-cycle clear request
//   sf_error_alarm_o : SoC error alarm, active-low, sticky
//   sf_error_code_o  : channels that faulted since the last accepted clear
//   sf_first_fault_o : lowest faulting channel on the last FAULT entry
//   sf_first_valid_o : sf_first_fault_o is valid
//   sf_fault_cnt_o   : FAULT entries since reset, saturating
//   sf_state_o       : 0 OK, 1 FAULT, 2 RECOVER
module safety_monitor_mc
  import safety_monitor_pkg::*;
#(
  parameter int NUM_ALARMS     = 5,
  parameter int FILTER_CYCLES  = 2,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_W          = 4,
  parameter int IDX_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ALARMS-1:0] alarm_in_n,
  input  logic [NUM_ALARMS-1:0] alarm_mask,
  input  logic                  clear_i,
  output logic                  sf_error_alarm_o,
  output logic [NUM_ALARMS-1:0] sf_error_code_o,
  output logic [IDX_W-1:0]      sf_first_fault_o,
  output logic                  sf_first_valid_o,
  output logic [CNT_W-1:0]      sf_fault_cnt_o,
  output logic [1:0]            sf_state_o
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

  logic [NUM_ALARMS-1:0] raw;
  logic [NUM_ALARMS-1:0] filt;
  logic                  any_filt;
  logic [IDX_W-1:0]      first_idx;

  assign raw      = ~alarm_in_n & ~alarm_mask;
  assign any_filt = |filt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_filt
      safety_monitor_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (raw[gi]),
        .filt_o(filt[gi])
      );
    end
  endgenerate

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (filt[i]) first_idx = IDX_W'(i);
    end
  end

  state_t                state_reg, state_next;
  logic [7:0]            hold_reg, hold_next;
  logic                  alarm_reg, alarm_next;
  logic [NUM_ALARMS-1:0] code_reg, code_next;
  logic [IDX_W-1:0]      first_reg, first_next;
  logic                  valid_reg, valid_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_OK;
      hold_reg  <= '0;
      alarm_reg <= 1'b1;
      code_reg  <= '0;
      first_reg <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      alarm_reg <= alarm_next;
      code_reg  <= code_next;
      first_reg <= first_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    alarm_next = alarm_reg;
    code_next  = code_reg | filt;
    first_next = first_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;

    unique case (state_reg)
      ST_OK, ST_RECOVER: begin
        if (any_filt) begin
          // Fault entry: capture and count, from OK or during hold-off.
          state_next = ST_FAULT;
          alarm_next = 1'b0;
          first_next = first_idx;
          valid_next = 1'b1;
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        end else if (state_reg == ST_RECOVER) begin
          if (hold_reg == 8'd0) begin
            state_next = ST_OK;
            alarm_next = 1'b1;
          end else begin
            hold_next = hold_reg - 8'd1;
          end
        end
      end
      ST_FAULT: begin
        // A still-active fault takes precedence over the clear request.
        if (clear_i && !any_filt) begin
          state_next = ST_RECOVER;
          hold_next  = HOLD_LOAD;
          code_next  = filt;
          valid_next = 1'b0;
        end
      end
      default: state_next = ST_OK;
    endcase
  end

  assign sf_error_alarm_o = alarm_reg;
  assign sf_error_code_o  = code_reg;
  assign sf_first_fault_o = first_reg;
  assign sf_first_valid_o = valid_reg;
  assign sf_fault_cnt_o   = cnt_reg;
  assign sf_state_o       = state_reg;

endmodule

// File: tb/tb_safety_monitor_mc.sv
// Scoreboard bench for safety_monitor_mc: the driver advances a behavioural
// model each cycle and queues the expected outputs; a monitor pops and
// compares one entry after every rising edge.
module tb_safety_monitor_mc;

  localparam int N    = 5;
  localparam int FC   = 2;
  localparam int HO   = 4;
  localparam int CMAX = 15;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] alarm_in_n;
  logic [N-1:0] alarm_mask;
  logic         clear_i;
  logic         sf_error_alarm_o;
  logic [N-1:0] sf_error_code_o;
  logic [2:0]   sf_first_fault_o;
  logic         sf_first_valid_o;
  logic [3:0]   sf_fault_cnt_o;
  logic [1:0]   sf_state_o;

  safety_monitor_mc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alarm_in_n      (alarm_in_n),
    .alarm_mask      (alarm_mask),
    .clear_i         (clear_i),
    .sf_error_alarm_o(sf_error_alarm_o),
    .sf_error_code_o (sf_error_code_o),
    .sf_first_fault_o(sf_first_fault_o),
    .sf_first_valid_o(sf_first_valid_o),
    .sf_fault_cnt_o  (sf_fault_cnt_o),
    .sf_state_o      (sf_state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit       alarm;
    bit [N-1:0] code;
    int       first;
    bit       valid;
    int       cnt;
    int       state;
  } exp_t;

  exp_t q[$];

  int       m_state;     // 0 OK, 1 FAULT, 2 RECOVER
  int       rec_left;    // cycles still to spend in RECOVER
  bit [N-1:0] m_filt;
  bit [N-1:0] m_code;
  int       m_first;
  bit       m_valid;
  int       m_cnt;
  int       run[N];      // consecutive cycles each channel has been raw-active

  function automatic void model_reset();
    m_state = 0; rec_left = 0; m_filt = '0; m_code = '0;
    m_first = 0; m_valid = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.alarm = (m_state == 0);
    e.code  = m_code;
    e.first = m_first;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    e.state = m_state;
    return e;
  endfunction

  function automatic void model_step(bit [N-1:0] a, bit [N-1:0] m, bit c);
    bit [N-1:0] raw;
    bit any;
    bit enter;
    bit leaving;
    raw = ~a & ~m;
    any = |m_filt;
    enter = 0;
    leaving = 0;
    case (m_state)
      0: enter = any;
      1: if (c && !any) begin
           leaving = 1; m_state = 2; rec_left = HO; m_valid = 0;
         end
      2: if (any) enter = 1;
         else begin
           rec_left--;
           if (rec_left == 0) m_state = 0;
         end
      default: ;
    endcase
    if (enter) begin
      m_state = 1;
      m_valid = 1;
      if (m_cnt < CMAX) m_cnt++;
      for (int i = 0; i < N; i++) if (m_filt[i]) begin m_first = i; break; end
    end
    m_code = leaving ? '0 : (m_code | m_filt);
    for (int i = 0; i < N; i++) begin
      run[i]    = raw[i] ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
      m_filt[i] = (run[i] >= FC);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(bit [N-1:0] a, bit [N-1:0] m, bit c);
    @(negedge clk);
    rst_n = 1'b1; alarm_in_n = a; alarm_mask = m; clear_i = c;
    model_step(a, m, c);
    q.push_back(model_out());
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive('1, alarm_mask, 1'b0);
  endtask

  task automatic clear_seq();
    idle(1);
    drive('1, alarm_mask, 1'b1);
    idle(HO + 1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; alarm_in_n = '1; clear_i = 1'b0;
    #1;
    check("rst_alarm", sf_error_alarm_o, 1);
    check("rst_code",  sf_error_code_o, 0);
    check("rst_first", sf_first_fault_o, 0);
    check("rst_valid", sf_first_valid_o, 0);
    check("rst_cnt",   sf_fault_cnt_o, 0);
    check("rst_state", sf_state_o, 0);
    model_reset();
    q.push_back(model_out());
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("alarm", sf_error_alarm_o, e.alarm);
        check("code",  sf_error_code_o, e.code);
        check("first", sf_first_fault_o, e.first);
        check("valid", sf_first_valid_o, e.valid);
        check("cnt",   sf_fault_cnt_o, e.cnt);
        check("state", sf_state_o, e.state);
        $display("cyc t=%0t alarm_n=%b mask=%b clr=%b -> alarm=%b code=%b first=%0d valid=%b cnt=%0d st=%0d",
                 $time, alarm_in_n, alarm_mask, clear_i, sf_error_alarm_o,
                 sf_error_code_o, sf_first_fault_o, sf_first_valid_o,
                 sf_fault_cnt_o, sf_state_o);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit [N-1:0] a;
    bit [N-1:0] m;
    rst_n = 1'b0; alarm_in_n = '1; alarm_mask = '0; clear_i = 1'b0;
    do_reset();
    idle(2);

    // Channel 2 held: FAULT entry on the third edge.
    repeat (4) drive(5'b11011, '0, 1'b0);
    after_edge();
    check("t1_alarm", sf_error_alarm_o, 0);
    check("t1_code",  sf_error_code_o, 5'b00100);
    check("t1_first", sf_first_fault_o, 2);
    check("t1_valid", sf_first_valid_o, 1);
    check("t1_cnt",   sf_fault_cnt_o, 1);
    clear_seq();
    after_edge();
    check("t1_back_ok", sf_error_alarm_o, 1);
    check("t1_code_clr", sf_error_code_o, 0);

    // Single-cycle glitch on channel 0 must be rejected.
    drive(5'b11110, '0, 1'b0);
    idle(4);
    after_edge();
    check("glitch_state", sf_state_o, 0);
    check("glitch_code",  sf_error_code_o, 0);

    // Channels 1 and 3 together: lowest index wins.
    repeat (3) drive(5'b10101, '0, 1'b0);
    after_edge();
    check("multi_first", sf_first_fault_o, 1);
    check("multi_code",  sf_error_code_o, 5'b01010);

    // Clear while channel 3 still filtered is ignored.
    drive(5'b10111, '0, 1'b1);
    drive(5'b10111, '0, 1'b0);
    after_edge();
    check("clr_ignored", sf_state_o, 1);
    drive('1, '0, 1'b0);
    drive('1, '0, 1'b1);
    after_edge();
    check("recover_state", sf_state_o, 2);
    check("recover_valid", sf_first_valid_o, 0);

    // New fault during hold-off re-enters FAULT.
    drive(5'b01111, '0, 1'b0);
    drive(5'b01111, '0, 1'b0);
    drive('1, '0, 1'b0);
    after_edge();
    check("refault_state", sf_state_o, 1);
    check("refault_first", sf_first_fault_o, 4);
    clear_seq();

    // Masked channel held active: no reaction.
    repeat (5) drive(5'b11110, 5'b00001, 1'b0);
    after_edge();
    check("mask_state", sf_state_o, 0);
    drive('1, '0, 1'b0);

    // Counter saturation.
    for (int k = 0; k < 17; k++) begin
      repeat (3) drive(5'b11110, '0, 1'b0);
      clear_seq();
    end
    after_edge();
    check("cnt_sat", sf_fault_cnt_o, CMAX);

    // Randomised traffic from a fresh reset.
    do_reset();
    a = '1; m = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (a[i]) a[i] = ($urandom_range(0, 19) != 0);
        else      a[i] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 63) == 0) m[i] = ~m[i];
      end
      drive(a, m, ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of FAULT.
    idle(2);
    repeat (4) drive(5'b11101, '0, 1'b0);
    after_edge();
    check("pre_rst_state", sf_state_o, 1);
    do_reset();
    idle(3);
    after_edge();
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
